// File: rtl/common_issue_queue.sv
// In-order issue queue with CDB operand wakeup; head issues when both operands are valid.
// Wakeup takes one cycle: broadcast at edge N gives issue at cycle N+1. Dispatch is dropped while queue_full.
module common_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        dispatch_en,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [5:0]  rs1_tag,
  input  logic [5:0]  rs2_tag,
  input  logic        rs1_data_valid,
  input  logic        rs2_data_valid,
  input  logic [5:0]  rd_tag,
  output logic        queue_full,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        exec_ready,
  output logic        issue_valid,
  output logic [31:0] issue_rs1_data,
  output logic [31:0] issue_rs2_data,
  output logic [5:0]  issue_rd_tag,
  output logic        queue_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] rs1_dat_q [DEPTH];
  logic [31:0] rs2_dat_q [DEPTH];
  logic [5:0]  rs1_tag_q [DEPTH];
  logic [5:0]  rs2_tag_q [DEPTH];
  logic [5:0]  rd_tag_q  [DEPTH];
  logic        rs1_vld_q [DEPTH];
  logic        rs2_vld_q [DEPTH];

  logic        push, pop;
  logic        in1_hit, in2_hit;
  logic        in1_vld, in2_vld;
  logic [31:0] in1_dat, in2_dat;

  assign queue_empty    = (count == '0);
  assign queue_full     = (count == CW'(DEPTH));
  assign issue_valid    = !queue_empty && rs1_vld_q[rd_ptr] && rs2_vld_q[rd_ptr];
  assign issue_rs1_data = rs1_dat_q[rd_ptr];
  assign issue_rs2_data = rs2_dat_q[rd_ptr];
  assign issue_rd_tag   = rd_tag_q[rd_ptr];

  assign push = dispatch_en && !queue_full && !flush;
  assign pop  = issue_valid && exec_ready && !flush;

  // Same-cycle broadcast is folded into the entry being written.
  assign in1_hit = cdb_valid && !rs1_data_valid && (rs1_tag == cdb_tag);
  assign in2_hit = cdb_valid && !rs2_data_valid && (rs2_tag == cdb_tag);
  assign in1_vld = rs1_data_valid || in1_hit;
  assign in2_vld = rs2_data_valid || in2_hit;
  assign in1_dat = in1_hit ? cdb_data : rs1_data;
  assign in2_dat = in2_hit ? cdb_data : rs2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_dat_q[i] <= '0;
        rs2_dat_q[i] <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rd_tag_q[i]  <= '0;
        rs1_vld_q[i] <= 1'b0;
        rs2_vld_q[i] <= 1'b0;
      end
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      // Waking a free slot is harmless: a later push overwrites every field.
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && !rs1_vld_q[i] && (rs1_tag_q[i] == cdb_tag)) begin
          rs1_dat_q[i] <= cdb_data;
          rs1_vld_q[i] <= 1'b1;
        end
        if (cdb_valid && !rs2_vld_q[i] && (rs2_tag_q[i] == cdb_tag)) begin
          rs2_dat_q[i] <= cdb_data;
          rs2_vld_q[i] <= 1'b1;
        end
      end

      if (push) begin
        rs1_dat_q[wr_ptr] <= in1_dat;
        rs2_dat_q[wr_ptr] <= in2_dat;
        rs1_tag_q[wr_ptr] <= rs1_tag;
        rs2_tag_q[wr_ptr] <= rs2_tag;
        rd_tag_q[wr_ptr]  <= rd_tag;
        rs1_vld_q[wr_ptr] <= in1_vld;
        rs2_vld_q[wr_ptr] <= in2_vld;
      end
    end
  end
endmodule

// File: tb/tb_common_issue_queue.sv
// Directed bench for common_issue_queue: dispatch, wakeup, full/flush and reset scenarios.
module tb_common_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n, flush, dispatch_en;
  logic [31:0] rs1_data, rs2_data;
  logic [5:0]  rs1_tag, rs2_tag, rd_tag;
  logic        rs1_data_valid, rs2_data_valid;
  logic        queue_full, queue_empty;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        exec_ready, issue_valid;
  logic [31:0] issue_rs1_data, issue_rs2_data;
  logic [5:0]  issue_rd_tag;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  common_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dispatch_en(dispatch_en),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_data_valid(rs1_data_valid), .rs2_data_valid(rs2_data_valid), .rd_tag(rd_tag),
    .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exec_ready(exec_ready), .issue_valid(issue_valid), .issue_rs1_data(issue_rs1_data),
    .issue_rs2_data(issue_rs2_data), .issue_rd_tag(issue_rd_tag), .queue_empty(queue_empty)
  );

  // Advance one edge; inputs are then changed 1ns after it, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dispatch(input logic en, input logic [31:0] d1, input logic v1, input logic [5:0] t1,
                              input logic [31:0] d2, input logic v2, input logic [5:0] t2,
                              input logic [5:0] rd);
    dispatch_en = en;
    rs1_data = d1; rs1_data_valid = v1; rs1_tag = t1;
    rs2_data = d2; rs2_data_valid = v2; rs2_tag = t2;
    rd_tag = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; exec_ready = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    set_dispatch(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    tick(); tick();
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", queue_empty); else pass_cnt++;
    total_cnt++; if (queue_full !== 1'b0) $display("FAIL reset_full got %b want 0", queue_full); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL reset_issue got %b want 0", issue_valid); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_issue();
    exec_ready = 1'b1;
    set_dispatch(1'b1, 32'd5, 1'b1, 6'h00, 32'd7, 1'b1, 6'h00, 6'd3);
    tick();
    dispatch_en = 1'b0;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL basic_issue got %b want 1", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_rs1_data !== 32'd5) $display("FAIL basic_rs1 got %0d want 5", issue_rs1_data); else pass_cnt++;
    total_cnt++; if (issue_rs2_data !== 32'd7) $display("FAIL basic_rs2 got %0d want 7", issue_rs2_data); else pass_cnt++;
    total_cnt++; if (issue_rd_tag !== 6'd3) $display("FAIL basic_rd got %0d want 3", issue_rd_tag); else pass_cnt++;
    tick();
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL basic_empty_after_pop got %b want 1", queue_empty); else pass_cnt++;
  endtask

  task automatic test_cdb_wakeup();
    exec_ready = 1'b1;
    set_dispatch(1'b1, 32'hDEAD, 1'b0, 6'h0A, 32'd2, 1'b1, 6'h00, 6'd5);
    tick();
    dispatch_en = 1'b0;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL wake_wait0 got %b want 0", issue_valid); else pass_cnt++;
    cdb_valid = 1'b1; cdb_tag = 6'h0B; cdb_data = 32'h5555;
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL wake_wrong_tag got %b want 0", issue_valid); else pass_cnt++;
    cdb_tag = 6'h0A; cdb_data = 32'h1234;
    #1;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL wake_not_comb got %b want 0", issue_valid); else pass_cnt++;
    tick();
    cdb_valid = 1'b0;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL wake_issue got %b want 1", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_rs1_data !== 32'h1234) $display("FAIL wake_rs1 got %h want 00001234", issue_rs1_data); else pass_cnt++;
    total_cnt++; if (issue_rd_tag !== 6'd5) $display("FAIL wake_rd got %0d want 5", issue_rd_tag); else pass_cnt++;
    tick();
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL wake_empty got %b want 1", queue_empty); else pass_cnt++;
  endtask

  task automatic test_dispatch_cdb();
    exec_ready = 1'b1;
    // rs1 already valid under the same tag: it must keep its dispatched value.
    set_dispatch(1'b1, 32'd9, 1'b1, 6'h11, 32'h0, 1'b0, 6'h11, 6'd6);
    cdb_valid = 1'b1; cdb_tag = 6'h11; cdb_data = 32'hBEEF;
    tick();
    dispatch_en = 1'b0; cdb_valid = 1'b0;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL coinc_issue got %b want 1", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_rs2_data !== 32'hBEEF) $display("FAIL coinc_rs2 got %h want 0000beef", issue_rs2_data); else pass_cnt++;
    total_cnt++; if (issue_rs1_data !== 32'd9) $display("FAIL coinc_rs1_kept got %0d want 9", issue_rs1_data); else pass_cnt++;
    tick();
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL coinc_empty got %b want 1", queue_empty); else pass_cnt++;
  endtask

  task automatic test_full_drain();
    exec_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_dispatch(1'b1, 32'(100 + i), 1'b1, 6'h00, 32'(200 + i), 1'b1, 6'h00, 6'(i));
      tick();
    end
    total_cnt++; if (queue_full !== 1'b1) $display("FAIL full_set got %b want 1", queue_full); else pass_cnt++;
    set_dispatch(1'b1, 32'd999, 1'b1, 6'h00, 32'd999, 1'b1, 6'h00, 6'd5);
    tick();
    dispatch_en = 1'b0;
    total_cnt++; if (queue_full !== 1'b1) $display("FAIL full_hold got %b want 1", queue_full); else pass_cnt++;
    total_cnt++; if (issue_rd_tag !== 6'd1) $display("FAIL full_head got %0d want 1", issue_rd_tag); else pass_cnt++;
    exec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total_cnt++;
      if (issue_valid !== 1'b1 || issue_rd_tag !== 6'(i) || issue_rs1_data !== 32'(100 + i))
        $display("FAIL drain_%0d got vld=%b rd=%0d rs1=%0d want vld=1 rd=%0d rs1=%0d",
                 i, issue_valid, issue_rd_tag, issue_rs1_data, i, 100 + i);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL drain_empty got %b want 1", queue_empty); else pass_cnt++;
  endtask

  task automatic test_full_pushpop_flush();
    exec_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      set_dispatch(1'b1, 32'(i), 1'b1, 6'h00, 32'(i), 1'b1, 6'h00, 6'(i));
      tick();
    end
    set_dispatch(1'b1, 32'd15, 1'b1, 6'h00, 32'd15, 1'b1, 6'h00, 6'd15);
    exec_ready = 1'b1;
    tick();
    dispatch_en = 1'b0; exec_ready = 1'b0;
    total_cnt++; if (queue_full !== 1'b0) $display("FAIL pp_not_full got %b want 0", queue_full); else pass_cnt++;
    total_cnt++; if (issue_rd_tag !== 6'd12) $display("FAIL pp_head got %0d want 12", issue_rd_tag); else pass_cnt++;
    exec_ready = 1'b1;
    tick(); tick(); tick();
    exec_ready = 1'b0;
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL pp_occ3 got empty=%b want 1", queue_empty); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      set_dispatch(1'b1, 32'd1, 1'b1, 6'h00, 32'd1, 1'b1, 6'h00, 6'd20);
      tick();
    end
    flush = 1'b1; exec_ready = 1'b1;
    tick();
    flush = 1'b0; dispatch_en = 1'b0;
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL flush_empty got %b want 1", queue_empty); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL flush_issue got %b want 0", issue_valid); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    exec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_dispatch(1'b1, 32'd3, 1'b1, 6'h00, 32'd4, 1'b1, 6'h00, 6'(30 + i));
      tick();
    end
    dispatch_en = 1'b0;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL ar_pre got %b want 1", issue_valid); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (queue_empty !== 1'b1) $display("FAIL ar_empty got %b want 1", queue_empty); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL ar_issue got %b want 0", issue_valid); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    set_dispatch(1'b1, 32'd42, 1'b1, 6'h00, 32'd43, 1'b1, 6'h00, 6'd40);
    tick();
    dispatch_en = 1'b0;
    total_cnt++;
    if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd40 || issue_rs1_data !== 32'd42)
      $display("FAIL ar_resume got vld=%b rd=%0d rs1=%0d want vld=1 rd=40 rs1=42",
               issue_valid, issue_rd_tag, issue_rs1_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_dispatch_cdb();
    test_full_drain();
    test_full_pushpop_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
